// File: rtl/seg7_bcd_counter.sv
// Multi-digit BCD up/down counter with prescaled tick, clear/load and wrap flag,
// driving a time-multiplexed seven-segment display (registered segments/digit_sel).
module seg7_bcd_counter #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 1000,
  parameter int SCAN_DIV     = 256,
  parameter bit COMMON_ANODE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  up_dn,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     digit_sel
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);

  logic [PW-1:0]       presc_q;
  logic [4*DIGITS-1:0] count_q, count_d;
  logic                wrap_q, wrap_d;
  logic [SW-1:0]       scan_cnt_q;
  logic [IW-1:0]       scan_idx_q;
  logic [6:0]          seg_q;
  logic [DIGITS-1:0]   sel_q;
  logic                tick;
  logic [3:0]          dig;
  logic                carry;
  logic [3:0]          cur_digit;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  assign tick = run && (presc_q == PRE_MAX);

  // Ripple carry/borrow through all digits in one cycle; carry out of the top is the wrap.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    dig     = 4'd0;
    carry   = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      for (int i = 0; i < DIGITS; i++) begin
        dig = load_val[4*i +: 4];
        count_d[4*i +: 4] = (dig > 4'd9) ? 4'd9 : dig;
      end
    end else if (tick) begin
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        dig = count_q[4*i +: 4];
        if (carry) begin
          if (up_dn) begin
            if (dig == 4'd9) begin
              dig   = 4'd0;
              carry = 1'b1;
            end else begin
              dig   = dig + 4'd1;
              carry = 1'b0;
            end
          end else begin
            if (dig == 4'd0) begin
              dig   = 4'd9;
              carry = 1'b1;
            end else begin
              dig   = dig - 4'd1;
              carry = 1'b0;
            end
          end
        end
        count_d[4*i +: 4] = dig;
      end
      wrap_d = carry;
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx_q == IW'(i)) cur_digit = count_q[4*i +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      if (clear || load) begin
        presc_q <= '0;
      end else if (run) begin
        presc_q <= (presc_q == PRE_MAX) ? '0 : presc_q + 1'b1;
      end
    end
  end

  // Scan runs free of run/clear/load; select and pattern come from the same index so they move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      seg_q      <= 7'h3F;
      sel_q      <= DIGITS'(1);
    end else begin
      seg_q <= seg7(cur_digit);
      sel_q <= DIGITS'(1) << scan_idx_q;
      if (scan_cnt_q == SCAN_MAX) begin
        scan_cnt_q <= '0;
        scan_idx_q <= (scan_idx_q == IDX_MAX) ? '0 : scan_idx_q + 1'b1;
      end else begin
        scan_cnt_q <= scan_cnt_q + 1'b1;
      end
    end
  end

  assign count     = count_q;
  assign wrap      = wrap_q;
  assign segments  = COMMON_ANODE ? ~seg_q : seg_q;
  assign digit_sel = COMMON_ANODE ? ~sel_q : sel_q;

endmodule
